mem_arbiter: RTL and testbench

Two-port arbiter that shares the single program/data RAM between the CPU control unit (port 0) and the host program loader (port 1).
- Grants one access at a time through a 3-state sequencer.
- Default policy is round-robin; a loader lock gives exclusive bursts for program download.
- Sits between CU/datapath memory signals (Meminst/MemWr path) and the RAM.

---
 rtl/mem_arbiter.sv | 116 +++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port RAM arbiter: CPU (port 0) and program loader (port 1) share one RAM
// through an IDLE -> ACC -> DONE sequencer with round-robin and loader lock.
module mem_arbiter #(
   parameter int unsigned AW = 5,
   parameter int unsigned DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic          cpu_wait,
   input  logic          ld_req,
   input  logic          ld_we,
   input  logic [AW-1:0] ld_addr,
   input  logic [DW-1:0] ld_wdata,
   input  logic          ld_lock,
   output logic          ld_ack,
   output logic [DW-1:0] rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_we,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic [1:0]    state
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      DONE = 2'b10
   } state_e;

   state_e        state_q, state_d;
   logic          sel_q, sel_d;
   logic          last_q, last_d;
   logic [AW-1:0] addr_hold_q, addr_hold_d;
   logic [DW-1:0] wdata_hold_q, wdata_hold_d;
   logic [DW-1:0] rdata_q, rdata_d;

   logic          grant_ld;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // Loader wins if alone, if the CPU went last, or if it holds the lock.
   assign grant_ld = ld_req & (~cpu_req | ~last_q | ld_lock);

   assign sel_we    = sel_q ? ld_we    : cpu_we;
   assign sel_addr  = sel_q ? ld_addr  : cpu_addr;
   assign sel_wdata = sel_q ? ld_wdata : cpu_wdata;

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      last_d       = last_q;
      addr_hold_d  = addr_hold_q;
      wdata_hold_d = wdata_hold_q;
      rdata_d      = rdata_q;
      cpu_ack      = 1'b0;
      ld_ack       = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = addr_hold_q;
      mem_wdata    = wdata_hold_q;
      case (state_q)
         IDLE: begin
            if (cpu_req || ld_req) begin
               sel_d   = grant_ld;
               state_d = ACC;
            end
         end
         ACC: begin
            mem_addr     = sel_addr;
            mem_wdata    = sel_wdata;
            mem_we       = sel_we;
            addr_hold_d  = sel_addr;
            wdata_hold_d = sel_wdata;
            rdata_d      = mem_rdata;
            state_d      = DONE;
         end
         DONE: begin
            cpu_ack = ~sel_q;
            ld_ack  = sel_q;
            last_d  = sel_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sel_q        <= 1'b0;
         last_q       <= 1'b1;
         addr_hold_q  <= '0;
         wdata_hold_q <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         last_q       <= last_d;
         addr_hold_q  <= addr_hold_d;
         wdata_hold_q <= wdata_hold_d;
         rdata_q      <= rdata_d;
      end
   end

   assign rdata    = rdata_q;
   assign busy     = (state_q != IDLE);
   assign state    = state_q;
   assign cpu_wait = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transactions are queued when
// requests are driven and matched against acks seen by a negedge monitor.
module tb_mem_arbiter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cpu_req, cpu_we, ld_req, ld_we, ld_lock;
   logic [4:0] cpu_addr, ld_addr, mem_addr;
   logic [7:0] cpu_wdata, ld_wdata, mem_wdata, rdata, mem_rdata;
   logic       cpu_ack, cpu_wait, ld_ack, mem_we, busy;
   logic [1:0] state;

   mem_arbiter #(.AW(5), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_wait(cpu_wait),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
      .ld_lock(ld_lock), .ld_ack(ld_ack), .rdata(rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .busy(busy), .state(state)
   );

   always #5 clk = ~clk;

   // RAM model: combinational read, write on rising edge.
   logic [7:0] ram [32];
   assign mem_rdata = ram[mem_addr];
   always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;

   typedef struct {
      logic       port;
      logic       we;
      logic [4:0] addr;
      logic [7:0] data;
      int         cyc;
   } txn_t;

   txn_t exp_q[$];
   txn_t obs_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   we_cnt  = 0;
   bit   both_ack = 1'b0;
   logic       acc_we;
   logic [4:0] acc_addr;
   logic [7:0] acc_wdata;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      txn_t t;
      if (state == 2'b01) begin
         acc_we    = mem_we;
         acc_addr  = mem_addr;
         acc_wdata = mem_wdata;
      end
      if (mem_we) we_cnt++;
      if (cpu_ack && ld_ack) both_ack = 1'b1;
      if (cpu_ack || ld_ack) begin
         t.port = ld_ack;
         t.we   = acc_we;
         t.addr = acc_addr;
         t.data = acc_we ? acc_wdata : rdata;
         t.cyc  = cyc;
         obs_q.push_back(t);
      end
   end

   function automatic txn_t mk(logic port, logic we, logic [4:0] addr, logic [7:0] data);
      txn_t t;
      t.port = port; t.we = we; t.addr = addr; t.data = data; t.cyc = 0;
      return t;
   endfunction

   // Step until n acks have been observed or the budget runs out.
   task automatic wait_obs(input int n, input int budget, output bit ok);
      for (int i = 0; i < budget && obs_q.size() < n; i++) @(posedge clk);
      #2;
      ok = (obs_q.size() >= n);
   endtask

   task automatic step;
      @(posedge clk); #2;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0; ld_lock = 0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_tests++;
         if ({state, busy, cpu_ack, ld_ack, mem_we, cpu_wait} !== 7'b0 ||
             mem_addr !== 5'h00 || mem_wdata !== 8'h00 || rdata !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_idle cyc%0d: state=%b busy=%b acks=%b%b we=%b addr=%h wd=%h rd=%h, required all 0",
                     i, state, busy, cpu_ack, ld_ack, mem_we, mem_addr, mem_wdata, rdata);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_cpu_read;
      bit ok; int c0; int w0; txn_t e, o;
      step;
      w0 = we_cnt;
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'h03;
      c0 = cyc;
      exp_q.push_back(mk(1'b0, 1'b0, 5'h03, 8'hA5));
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (state !== 2'b01 || mem_addr !== 5'h03 || mem_we !== 1'b0 || cpu_wait !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL cpu_read_acc: state=%b addr=%h we=%b wait=%b busy=%b, required 01/03/0/1/1",
                  state, mem_addr, mem_we, cpu_wait, busy);
      end
      wait_obs(1, 10, ok);
      cpu_req = 0;
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL cpu_read_timeout: acks=%0d, required 1", obs_q.size()); end
      while (ok && exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_tests++;
         if (o.port !== e.port || o.addr !== e.addr || o.data !== e.data || o.cyc - c0 != 2) begin
            n_fail++;
            $display("FAIL cpu_read_txn: port=%b addr=%h rdata=%h lat=%0d, required %b/%h/%h/2",
                     o.port, o.addr, o.data, o.cyc - c0, e.port, e.addr, e.data);
         end
      end
      n_tests++;
      if (we_cnt != w0) begin n_fail++; $display("FAIL cpu_read_we: strobes=%0d, required 0", we_cnt - w0); end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_ld_write;
      bit ok; int w0; txn_t e, o;
      step;
      w0 = we_cnt;
      ld_req = 1; ld_we = 1; ld_addr = 5'h1F; ld_wdata = 8'h3C;
      exp_q.push_back(mk(1'b1, 1'b1, 5'h1F, 8'h3C));
      wait_obs(1, 10, ok);
      ld_req = 0; ld_we = 0;
      step; step;
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL ld_write_timeout: acks=%0d, required 1", obs_q.size()); end
      while (ok && exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_tests++;
         if (o.port !== e.port || o.we !== e.we || o.addr !== e.addr || o.data !== e.data) begin
            n_fail++;
            $display("FAIL ld_write_txn: port=%b we=%b addr=%h data=%h, required %b/%b/%h/%h",
                     o.port, o.we, o.addr, o.data, e.port, e.we, e.addr, e.data);
         end
      end
      n_tests++;
      if (we_cnt - w0 != 1 || ram[31] !== 8'h3C || obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL ld_write_once: strobes=%0d ram1F=%h extra_acks=%0d, required 1/3c/0",
                  we_cnt - w0, ram[31], obs_q.size());
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_round_robin;
      bit ok; int i; int pc; txn_t e, o;
      test_reset();
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'h04;
      ld_req  = 1; ld_we  = 0; ld_addr  = 5'h08;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(mk(1'b0, 1'b0, 5'h04, 8'h44));
         exp_q.push_back(mk(1'b1, 1'b0, 5'h08, 8'h88));
      end
      wait_obs(4, 40, ok);
      cpu_req = 0; ld_req = 0;
      step; step; step;
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rr_timeout: acks=%0d, required 4", obs_q.size()); end
      i = 0; pc = 0;
      while (ok && exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_tests++;
         if (o.port !== e.port || o.addr !== e.addr || o.data !== e.data || (i > 0 && o.cyc - pc != 3)) begin
            n_fail++;
            $display("FAIL rr_grant%0d: port=%b addr=%h data=%h gap=%0d, required %b/%h/%h/3",
                     i, o.port, o.addr, o.data, o.cyc - pc, e.port, e.addr, e.data);
         end
         pc = o.cyc; i++;
      end
      n_tests++;
      if (obs_q.size() != 0 || both_ack) begin
         n_fail++;
         $display("FAIL rr_extra: extra_acks=%0d both=%b, required 0/0", obs_q.size(), both_ack);
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_lock;
      bit ok; int i; txn_t e, o;
      // Loader was granted last in the preceding round-robin run.
      ld_lock = 1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 5'h04;
      ld_req  = 1; ld_we  = 0; ld_addr  = 5'h08;
      repeat (4) exp_q.push_back(mk(1'b1, 1'b0, 5'h08, 8'h88));
      wait_obs(4, 40, ok);
      ld_lock = 0;
      exp_q.push_back(mk(1'b0, 1'b0, 5'h04, 8'h44));
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL lock_timeout: acks=%0d, required 4", obs_q.size()); end
      wait_obs(5, 20, ok);
      cpu_req = 0; ld_req = 0;
      step; step; step;
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL unlock_timeout: acks=%0d, required 5", obs_q.size()); end
      i = 0;
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_tests++;
         if (o.port !== e.port || o.addr !== e.addr || o.data !== e.data) begin
            n_fail++;
            $display("FAIL lock_grant%0d: port=%b addr=%h data=%h, required %b/%h/%h",
                     i, o.port, o.addr, o.data, e.port, e.addr, e.data);
         end
         i++;
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid_access;
      bit ok; txn_t e, o;
      step;
      cpu_req = 1; cpu_we = 1; cpu_addr = 5'h0A; cpu_wdata = 8'h77;
      exp_q.push_back(mk(1'b0, 1'b1, 5'h0A, 8'h77));
      step;
      n_tests++;
      if (state !== 2'b01 || mem_we !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pre_acc: state=%b we=%b, required 01/1", state, mem_we);
      end
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (state !== 2'b00 || mem_we !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_acc: state=%b we=%b busy=%b, required 00/0/0", state, mem_we, busy);
      end
      step; step;
      n_tests++;
      if (obs_q.size() != 0 || cpu_ack !== 1'b0 || ram[10] === 8'h77) begin
         n_fail++;
         $display("FAIL rst_no_ack: acks=%0d ram0A=%h, required 0 acks and no write", obs_q.size(), ram[10]);
      end
      rst_n = 1'b1;
      wait_obs(1, 10, ok);
      cpu_req = 0; cpu_we = 0;
      step; step;
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rst_regrant_timeout: acks=%0d, required 1", obs_q.size()); end
      while (ok && exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_tests++;
         if (o.port !== e.port || o.we !== e.we || o.addr !== e.addr || o.data !== e.data || ram[10] !== 8'h77) begin
            n_fail++;
            $display("FAIL rst_regrant_txn: port=%b we=%b addr=%h data=%h ram=%h, required %b/%b/%h/%h/77",
                     o.port, o.we, o.addr, o.data, ram[10], e.port, e.we, e.addr, e.data);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) ram[i] = 8'h00;
      ram[3] = 8'hA5;
      ram[4] = 8'h44;
      ram[8] = 8'h88;
      test_reset();
      test_cpu_read();
      test_ld_write();
      test_round_robin();
      test_lock();
      test_reset_mid_access();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: sim time exceeded, required completion");
      $fatal(1);
   end

endmodule
